usb_port_switch: RTL and testbench

USB_PORT_SWITCH -- requirements
Module: usb_port_switch

---
 rtl/usb_port_switch.sv | 186 ++++++++++++++++++
 tb/tb_usb_port_switch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/usb_port_switch.sv
// usb_port_switch: hands one shared FX2 slave-FIFO bus between NUM_CH
// protocol engines. A change of the synchronised owner request first
// drains the current owner (until it reports idle or a timeout expires),
// then idles the bus for TURN_CYC turnaround cycles before granting the
// new owner.
module usb_port_switch #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 8,
    parameter int TURN_CYC  = 2,
    parameter int DRAIN_MAX = 255,
    localparam int CW       = $clog2(NUM_CH)
) (
    input  logic                     IFCLK,
    input  logic                     ARESETN,
    input  logic [CW-1:0]            MODE_REQ,
    input  logic                     FLAGA,
    input  logic                     FLAGB,
    input  logic [DATA_W-1:0]        DB_I,
    input  logic [NUM_CH-1:0]        ENG_IDLE,
    input  logic [NUM_CH-1:0]        SLRD_C,
    input  logic [NUM_CH-1:0]        SLWR_C,
    input  logic [NUM_CH-1:0]        SLOE_C,
    input  logic [NUM_CH-1:0]        PKTEND_C,
    input  logic [2*NUM_CH-1:0]      FIFOADR_C,
    input  logic [NUM_CH*DATA_W-1:0] DB_O_C,
    input  logic [NUM_CH*DATA_W-1:0] DB_T_C,
    output logic                     SLRD,
    output logic                     SLWR,
    output logic                     SLOE,
    output logic                     PKTEND,
    output logic [1:0]               FIFOADR,
    output logic [DATA_W-1:0]        DB_O,
    output logic [DATA_W-1:0]        DB_T,
    output logic [NUM_CH-1:0]        FLAGA_C,
    output logic [NUM_CH-1:0]        FLAGB_C,
    output logic [NUM_CH*DATA_W-1:0] DB_I_C,
    output logic [NUM_CH-1:0]        GRANT,
    output logic [CW-1:0]            ACTIVE_MODE,
    output logic                     SWITCHING,
    output logic                     DRAIN_TO
);

    typedef enum logic [1:0] {
        TURN  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0]       TURN_LAST  = 16'(TURN_CYC - 1);
    localparam logic [15:0]       DRAIN_LAST = 16'(DRAIN_MAX - 1);
    localparam logic [NUM_CH-1:0] GRANT_ONE  = NUM_CH'(1);

    state_t              state_reg, state_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic [CW-1:0]       target_reg, target_next;
    logic [CW-1:0]       active_reg, active_next;
    logic [NUM_CH-1:0]   grant_reg, grant_next;
    logic                drain_to_reg, drain_to_next;
    logic [CW-1:0]       req_meta_reg, req_s_reg;
    logic                req_valid;
    logic                owner_idle;

    // Two-flop synchroniser for the asynchronous owner request.
    always_ff @(posedge IFCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            req_meta_reg <= '0;
            req_s_reg    <= '0;
        end else begin
            req_meta_reg <= MODE_REQ;
            req_s_reg    <= req_meta_reg;
        end
    end

    // Out-of-range requests are ignored; the current target stands.
    assign req_valid  = (32'(req_s_reg) < NUM_CH);
    assign owner_idle = ENG_IDLE[active_reg];

    // Switch FSM state and bookkeeping registers.
    always_ff @(posedge IFCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg    <= TURN;
            cnt_reg      <= '0;
            target_reg   <= '0;
            active_reg   <= '0;
            grant_reg    <= '0;
            drain_to_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            target_reg   <= target_next;
            active_reg   <= active_next;
            grant_reg    <= grant_next;
            drain_to_reg <= drain_to_next;
        end
    end

    // Next-state logic: OWN -> DRAIN on a new request, DRAIN -> TURN on idle
    // or timeout, TURN -> OWN after the turnaround (restarted by new requests).
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        target_next   = target_reg;
        active_next   = active_reg;
        grant_next    = grant_reg;
        drain_to_next = drain_to_reg;
        case (state_reg)
            OWN: begin
                if (req_valid && (req_s_reg != active_reg)) begin
                    state_next  = DRAIN;
                    target_next = req_s_reg;
                    cnt_next    = '0;
                end
            end
            DRAIN: begin
                // The owner keeps the bus; only the destination follows req_s.
                if (req_valid) begin
                    target_next = req_s_reg;
                end
                if (owner_idle || (cnt_reg == DRAIN_LAST)) begin
                    state_next = TURN;
                    cnt_next   = '0;
                    grant_next = '0;
                    if (!owner_idle) begin
                        drain_to_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            TURN: begin
                if (req_valid && (req_s_reg != target_reg)) begin
                    target_next = req_s_reg;
                    cnt_next    = '0;
                end else if (cnt_reg == TURN_LAST) begin
                    state_next  = OWN;
                    cnt_next    = '0;
                    active_next = target_reg;
                    grant_next  = GRANT_ONE << target_reg;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = TURN;
                cnt_next   = '0;
                grant_next = '0;
            end
        endcase
    end

    // FX2-side mux: idle bus in TURN, otherwise the current owner drives it.
    always_comb begin
        SLRD    = 1'b1;
        SLWR    = 1'b1;
        SLOE    = 1'b1;
        PKTEND  = 1'b1;
        FIFOADR = 2'b00;
        DB_O    = '0;
        DB_T    = '1;
        if (state_reg != TURN) begin
            SLRD    = SLRD_C[active_reg];
            SLWR    = SLWR_C[active_reg];
            SLOE    = SLOE_C[active_reg];
            PKTEND  = PKTEND_C[active_reg];
            FIFOADR = FIFOADR_C[2*active_reg +: 2];
            DB_O    = DB_O_C[active_reg*DATA_W +: DATA_W];
            DB_T    = DB_T_C[active_reg*DATA_W +: DATA_W];
        end
    end

    // Engine side: flags reach only the owner while it owns the bus; read
    // data goes to everyone.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign FLAGA_C[gi] = (grant_reg[gi] && (state_reg == OWN)) ? FLAGA : 1'b1;
            assign FLAGB_C[gi] = (grant_reg[gi] && (state_reg == OWN)) ? FLAGB : 1'b1;
            assign DB_I_C[gi*DATA_W +: DATA_W] = DB_I;
        end
    endgenerate

    assign GRANT       = grant_reg;
    assign ACTIVE_MODE = active_reg;
    assign SWITCHING   = (state_reg != OWN);
    assign DRAIN_TO    = drain_to_reg;

endmodule

// File: tb/tb_usb_port_switch.sv
// Directed bench for usb_port_switch with three engines, TURN_CYC=2 and
// DRAIN_MAX=8. Outputs are sampled on the falling clock edge.
module tb_usb_port_switch;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int CW     = 2;

    logic                     IFCLK = 1'b0;
    logic                     ARESETN;
    logic [CW-1:0]            MODE_REQ;
    logic                     FLAGA, FLAGB;
    logic [DATA_W-1:0]        DB_I;
    logic [NUM_CH-1:0]        ENG_IDLE;
    logic [NUM_CH-1:0]        SLRD_C, SLWR_C, SLOE_C, PKTEND_C;
    logic [2*NUM_CH-1:0]      FIFOADR_C;
    logic [NUM_CH*DATA_W-1:0] DB_O_C, DB_T_C;
    logic                     SLRD, SLWR, SLOE, PKTEND;
    logic [1:0]               FIFOADR;
    logic [DATA_W-1:0]        DB_O, DB_T;
    logic [NUM_CH-1:0]        FLAGA_C, FLAGB_C;
    logic [NUM_CH*DATA_W-1:0] DB_I_C;
    logic [NUM_CH-1:0]        GRANT;
    logic [CW-1:0]            ACTIVE_MODE;
    logic                     SWITCHING, DRAIN_TO;

    int checks = 0;
    int errors = 0;

    usb_port_switch #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TURN_CYC(2), .DRAIN_MAX(8)
    ) dut (
        .IFCLK(IFCLK), .ARESETN(ARESETN), .MODE_REQ(MODE_REQ),
        .FLAGA(FLAGA), .FLAGB(FLAGB), .DB_I(DB_I), .ENG_IDLE(ENG_IDLE),
        .SLRD_C(SLRD_C), .SLWR_C(SLWR_C), .SLOE_C(SLOE_C), .PKTEND_C(PKTEND_C),
        .FIFOADR_C(FIFOADR_C), .DB_O_C(DB_O_C), .DB_T_C(DB_T_C),
        .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .PKTEND(PKTEND),
        .FIFOADR(FIFOADR), .DB_O(DB_O), .DB_T(DB_T),
        .FLAGA_C(FLAGA_C), .FLAGB_C(FLAGB_C), .DB_I_C(DB_I_C),
        .GRANT(GRANT), .ACTIVE_MODE(ACTIVE_MODE),
        .SWITCHING(SWITCHING), .DRAIN_TO(DRAIN_TO)
    );

    always #5 IFCLK = ~IFCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge IFCLK);
        @(negedge IFCLK);
    endtask

    int n;

    initial begin
        ARESETN   = 1'b0;
        MODE_REQ  = 2'd0;
        FLAGA     = 1'b0;
        FLAGB     = 1'b0;
        DB_I      = 8'h5A;
        ENG_IDLE  = 3'b000;
        SLRD_C    = 3'b110;            // ch0 reading
        SLWR_C    = 3'b101;            // ch1 writing
        SLOE_C    = 3'b011;            // ch2 output-enable
        PKTEND_C  = 3'b111;
        FIFOADR_C = 6'b10_01_11;       // ch0=3, ch1=1, ch2=2
        DB_O_C    = {8'hC2, 8'hB1, 8'hA0};
        DB_T_C    = {8'h0F, 8'hF0, 8'h00};

        // Reset state
        tick(); tick();
        check("rst_grant", 32'(GRANT), 32'h0);
        check("rst_switching", 32'(SWITCHING), 32'h1);
        check("rst_drain_to", 32'(DRAIN_TO), 32'h0);
        check("rst_active", 32'(ACTIVE_MODE), 32'h0);
        check("rst_slrd", 32'(SLRD), 32'h1);
        check("rst_db_t", 32'(DB_T), 32'hFF);
        check("rst_dbi_bcast", 32'(DB_I_C), 32'h5A5A5A);

        // Release: two turnaround cycles, then channel 0 is granted
        ARESETN = 1'b1;
        tick();
        check("rel_turn1_grant", 32'(GRANT), 32'h0);
        tick();
        check("rel_own_grant", 32'(GRANT), 32'h1);
        check("own0_switching", 32'(SWITCHING), 32'h0);
        check("own0_slrd", 32'(SLRD), 32'h0);
        check("own0_slwr", 32'(SLWR), 32'h1);
        check("own0_fifoadr", 32'(FIFOADR), 32'h3);
        check("own0_db_o", 32'(DB_O), 32'hA0);
        check("own0_db_t", 32'(DB_T), 32'h00);
        check("own0_flaga_c", 32'(FLAGA_C), 32'h6);
        check("own0_flagb_c", 32'(FLAGB_C), 32'h6);

        // Switch 0 -> 1, owner reports idle in its fifth drain cycle
        MODE_REQ = 2'd1;
        tick(); tick();
        check("sync_still_own", 32'(SWITCHING), 32'h0);
        tick();
        check("drain_flaga_c", 32'(FLAGA_C), 32'h7);
        check("drain_slrd_routed", 32'(SLRD), 32'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_cyc%0d_grant", i), 32'(GRANT), 32'h1);
            check($sformatf("drain_cyc%0d_sw", i), 32'(SWITCHING), 32'h1);
            if (i == 4) ENG_IDLE = 3'b001;
            tick();
        end
        check("turn1_grant", 32'(GRANT), 32'h0);
        check("turn1_db_t", 32'(DB_T), 32'hFF);
        check("turn1_slrd", 32'(SLRD), 32'h1);
        check("turn1_slwr", 32'(SLWR), 32'h1);
        check("turn1_db_o", 32'(DB_O), 32'h00);
        check("turn1_fifoadr", 32'(FIFOADR), 32'h0);
        tick();
        check("turn2_grant", 32'(GRANT), 32'h0);
        tick();
        ENG_IDLE = 3'b000;
        check("own1_grant", 32'(GRANT), 32'h2);
        check("own1_active", 32'(ACTIVE_MODE), 32'h1);
        check("own1_drain_to", 32'(DRAIN_TO), 32'h0);
        check("own1_slwr", 32'(SLWR), 32'h0);
        check("own1_fifoadr", 32'(FIFOADR), 32'h1);
        check("own1_db_o", 32'(DB_O), 32'hB1);
        check("own1_flaga_c", 32'(FLAGA_C), 32'h5);

        // Out-of-range request is ignored
        MODE_REQ = 2'd3;
        for (int i = 0; i < 5; i++) tick();
        check("bad_req_grant", 32'(GRANT), 32'h2);
        check("bad_req_switching", 32'(SWITCHING), 32'h0);

        // Switch 1 -> 0 with owner never idle: 8-cycle drain timeout
        MODE_REQ = 2'd0;
        tick(); tick(); tick();
        n = 0;
        while (GRANT != 3'b000 && SWITCHING && n < 20) begin
            n++;
            tick();
        end
        check("timeout_drain_cycles", 32'(n), 32'd8);
        check("timeout_drain_to", 32'(DRAIN_TO), 32'h1);
        tick(); tick();
        check("own0b_grant", 32'(GRANT), 32'h1);

        // Switch 0 -> 1, request moves to 2 during turnaround: restart
        ENG_IDLE = 3'b001;
        MODE_REQ = 2'd1;
        tick(); tick(); tick();
        check("r41_drain_sw", 32'(SWITCHING), 32'h1);
        MODE_REQ = 2'd2;
        tick();
        check("r41_turn1_grant", 32'(GRANT), 32'h0);
        tick();
        check("r41_turn2_grant", 32'(GRANT), 32'h0);
        tick();
        check("r41_restart_grant", 32'(GRANT), 32'h0);
        tick();
        check("r41_restart2_grant", 32'(GRANT), 32'h0);
        tick();
        check("r41_own2_grant", 32'(GRANT), 32'h4);
        check("r41_own2_active", 32'(ACTIVE_MODE), 32'h2);
        check("r41_drain_to_sticky", 32'(DRAIN_TO), 32'h1);
        ENG_IDLE = 3'b000;

        // Reset mid-transfer drops strobes and grant immediately
        SLWR_C = 3'b000;
        #1;
        check("pre_rst_slwr", 32'(SLWR), 32'h0);
        MODE_REQ = 2'd0;
        ARESETN  = 1'b0;
        #1;
        check("async_rst_slwr", 32'(SLWR), 32'h1);
        check("async_rst_grant", 32'(GRANT), 32'h0);
        check("async_rst_drain_to", 32'(DRAIN_TO), 32'h0);
        check("async_rst_switching", 32'(SWITCHING), 32'h1);
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        check("rerel_turn_grant", 32'(GRANT), 32'h0);
        tick();
        check("rerel_own_grant", 32'(GRANT), 32'h1);
        check("rerel_slwr", 32'(SLWR), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
